unibus_arbiter: RTL and testbench
=================================

# unibus_arbiter

Round-robin arbiter and sequencer for the 4-bit unidirectional bus. Four requesters each present a 4-bit word. The block grants one requester at a time, latches its word and drives the bus data input (`inp`) and bus enable (`c`) for a fixed number of cycles. Each transfer ends with a one-cycle completion pulse back to the granted requester.

## Interface
Parameters:
- `W`, 4: bus data width; must match the bus `inp`/`o` width.
- `HOLD`, 2: cycles `bus_c` stays high per transfer; legal range 1..15.

Ports:
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  request per requester; bit i belongs to requester i.
- `din`  in  4*W  packed requester words; requester i is `din[i*W +: W]`.
- `gnt`  out  4  one-hot grant; high for the whole transfer.
- `bus_d`  out  W  data to the bus `inp`.
- `bus_c`  out  1  enable to the bus `c`.
- `done`  out  4  one-hot, one-cycle completion pulse to the granted requester.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- State machine: IDLE → XFER → DONE → IDLE.
- **IDLE**
  - `gnt`=0, `bus_c`=0, `bus_d`=0, `done`=0.
  - If `req`≠0, select the first set bit, searching upward from pointer `ptr` (2 bits) with wrap 3→0.
  - Latch the selected index and `din` slice, clear the hold counter, then go to XFER.
- **XFER**
  - `gnt`=one-hot of the latched index, `bus_d`=latched word, `bus_c`=1.
  - A 4-bit counter increments each cycle. Leave XFER after exactly `HOLD` cycles.
  - `bus_d` is stable for the whole XFER. Changes on `din` or `req` during XFER are ignored.
- **DONE**
  - `done[idx]`=1 for one cycle, `gnt`=0, `bus_c`=0, `bus_d`=0.
  - `ptr` ← idx+1 mod 4, then go to IDLE.
- Fairness: the last-served requester has lowest priority on the next arbitration. With all four requesting continuously, grant order is 0,1,2,3,0,…
- `req` is level-sensitive and sampled only in IDLE.
  - A requester that drops `req` during XFER still gets its transfer and `done`.
  - A requester that keeps `req` high after `done` re-competes at the next IDLE.
- No default grant: if `req`=0 in IDLE, the block stays in IDLE indefinitely with all outputs 0.

## Timing
- Reset, taking effect at the next rising edge when `rst`=1:
  - state=IDLE, `ptr`=0, counter=0, latched index/word=0.
  - `gnt`=0, `bus_d`=0, `bus_c`=0, `done`=0, `busy`=0.
- Reset during XFER or DONE aborts the transfer. No `done` pulse is issued, and `bus_c` is low from the cycle after the reset edge.
- Latency: with `req` sampled high in IDLE at edge k:
  - `gnt`, `bus_c` and `bus_d` are valid from edge k+1 through edge k+HOLD.
  - `done` is high from edge k+HOLD+1 for one cycle.
  - IDLE resumes at edge k+HOLD+2.
- Throughput: one transfer per HOLD+2 cycles under continuous requests.
- All outputs are registered and glitch-free. `gnt` and `bus_c` rise and fall on the same edges.
- `busy`=1 from edge k+1 through the DONE cycle.

## Test plan
- **Reset values:** hold `rst`=1 for 3 cycles with `req`=4'b1111 → all outputs 0; first grant after release is `gnt`=4'b0001.
- **Single transfer:** `req`=4'b0100 with `din` slice 2 = 4'hA, `HOLD`=2 → `gnt`=4'b0100 and `bus_c`=1 / `bus_d`=4'hA for exactly 2 cycles, then `done`=4'b0100 for 1 cycle, then IDLE.
- **Round-robin:** `req`=4'b1111 held → `gnt` sequence 0001,0010,0100,1000,0001; each grant block is 4 cycles apart with `HOLD`=2.
- **Fairness skip and wrap:** after serving requester 3, `req`=4'b1001 → next grant is requester 0. After serving requester 0 with `req`=4'b1001 → next grant is requester 3.
- **Data and request changes mid-XFER:** `req` drops and `din` changes from 4'h5 to 4'hF during XFER → `bus_d` stays 4'h5 for the whole XFER and `done` is still pulsed.
- **Reset mid-transfer:** assert `rst` in the first XFER cycle → no `done` pulse, `bus_c`=0 next cycle, `ptr`=0; the following grant goes to the lowest-indexed requester.

Source files
------------

// File: rtl/unibus_arbiter.sv
// Round-robin arbiter and sequencer for the 4-bit unidirectional bus.
// Grants one of four requesters, holds its word on the bus, then pulses done.
module unibus_arbiter #(
  parameter int W    = 4,
  parameter int HOLD = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] din,
  output logic [3:0]     gnt,
  output logic [W-1:0]   bus_d,
  output logic           bus_c,
  output logic [3:0]     done,
  output logic           busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] LAST = 4'(HOLD - 1);

  logic [1:0]   state;
  logic [1:0]   ptr;
  logic [3:0]   cnt;
  logic [1:0]   idx;
  logic [W-1:0] word;

  logic [1:0]   sel;
  logic         hit;

  // First requester at or above ptr, wrapping 3 -> 0.
  always_comb begin
    sel = 2'd0;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!hit && req[ptr + 2'(i)]) begin
        hit = 1'b1;
        sel = ptr + 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd0;
      cnt   <= 4'd0;
      idx   <= 2'd0;
      word  <= '0;
      gnt   <= 4'd0;
      bus_d <= '0;
      bus_c <= 1'b0;
      done  <= 4'd0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 4'd0;
          if (hit) begin
            state <= XFER;
            idx   <= sel;
            word  <= din[sel*W +: W];
            cnt   <= 4'd0;
            gnt   <= 4'b0001 << sel;
            bus_d <= din[sel*W +: W];
            bus_c <= 1'b1;
            busy  <= 1'b1;
          end
        end
        XFER: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST) begin
            state <= DONE;
            gnt   <= 4'd0;
            bus_d <= '0;
            bus_c <= 1'b0;
            done  <= 4'b0001 << idx;
          end
        end
        DONE: begin
          state <= IDLE;
          ptr   <= idx + 2'd1;
          done  <= 4'd0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'd0;
          bus_d <= '0;
          bus_c <= 1'b0;
          done  <= 4'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unibus_arbiter.sv
// Directed bench for unibus_arbiter with HOLD=2.
// Outputs are sampled 1ns after each rising edge.
module tb_unibus_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] din;
  logic [3:0]  gnt;
  logic [3:0]  bus_d;
  logic        bus_c;
  logic [3:0]  done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  unibus_arbiter #(.W(4), .HOLD(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .din   (din),
    .gnt   (gnt),
    .bus_d (bus_d),
    .bus_c (bus_c),
    .done  (done),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] o,
                     input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".gnt"},   16'(gnt),   16'h0);
    chk({tag, ".bus_c"}, 16'(bus_c), 16'h0);
    chk({tag, ".bus_d"}, 16'(bus_d), 16'h0);
    chk({tag, ".done"},  16'(done),  16'h0);
    chk({tag, ".busy"},  16'(busy),  16'h0);
  endtask

  task automatic chk_xfer(input string tag,
                          input logic [3:0] eg,
                          input logic [3:0] ed);
    chk({tag, ".gnt"},   16'(gnt),   16'(eg));
    chk({tag, ".bus_c"}, 16'(bus_c), 16'h1);
    chk({tag, ".bus_d"}, 16'(bus_d), 16'(ed));
    chk({tag, ".done"},  16'(done),  16'h0);
    chk({tag, ".busy"},  16'(busy),  16'h1);
  endtask

  task automatic chk_done(input string tag, input logic [3:0] eg);
    chk({tag, ".gnt"},   16'(gnt),   16'h0);
    chk({tag, ".bus_c"}, 16'(bus_c), 16'h0);
    chk({tag, ".bus_d"}, 16'(bus_d), 16'h0);
    chk({tag, ".done"},  16'(done),  16'(eg));
    chk({tag, ".busy"},  16'(busy),  16'h1);
  endtask

  // Full transfer starting from IDLE: two XFER cycles, DONE, back to IDLE.
  task automatic xfer(input string tag,
                      input logic [3:0] r,
                      input logic [15:0] d,
                      input logic [3:0] eg,
                      input logic [3:0] ed);
    req = r;
    din = d;
    step();
    chk_xfer({tag, ".x1"}, eg, ed);
    step();
    chk_xfer({tag, ".x2"}, eg, ed);
    step();
    chk_done({tag, ".dn"}, eg);
    step();
    chk_idle({tag, ".id"});
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b1111;
    din = 16'h4321;

    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("rst");
    end
    rst = 1'b0;

    xfer("rr0", 4'b1111, 16'h4321, 4'b0001, 4'h1);
    xfer("rr1", 4'b1111, 16'h4321, 4'b0010, 4'h2);
    xfer("rr2", 4'b1111, 16'h4321, 4'b0100, 4'h3);
    xfer("rr3", 4'b1111, 16'h4321, 4'b1000, 4'h4);
    xfer("rr4", 4'b1111, 16'h4321, 4'b0001, 4'h1);

    req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("noreq");
    end

    xfer("single", 4'b0100, 16'h0A00, 4'b0100, 4'hA);
    xfer("serve3", 4'b1000, 16'h9007, 4'b1000, 4'h9);
    xfer("wrap0",  4'b1001, 16'h9007, 4'b0001, 4'h7);
    xfer("skip3",  4'b1001, 16'h9007, 4'b1000, 4'h9);

    req = 4'b0010;
    din = 16'h0050;
    step();
    chk_xfer("mid.x1", 4'b0010, 4'h5);
    req = 4'b0000;
    din = 16'h00F0;
    step();
    chk_xfer("mid.x2", 4'b0010, 4'h5);
    step();
    chk_done("mid.dn", 4'b0010);
    step();
    chk_idle("mid.id");

    req = 4'b0100;
    din = 16'h0300;
    step();
    chk_xfer("abort.x1", 4'b0100, 4'h3);
    rst = 1'b1;
    step();
    chk_idle("abort.rst");
    rst = 1'b0;
    req = 4'b1110;
    din = 16'h4321;
    step();
    chk_xfer("abort.nx1", 4'b0010, 4'h2);
    step();
    chk_xfer("abort.nx2", 4'b0010, 4'h2);
    step();
    chk_done("abort.ndn", 4'b0010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
